// File: rtl/psum_unpacker.sv
// Consumer end of the packed partial-sum bus: buffers 4-lane packed words tagged with a
// reduction mode and serializes them into lane results over a valid/ready stream.
module psum_unpacker #(
  parameter int unsigned LANE_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [4*LANE_W-1:0]       in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W-1:0]         out_data,
  output logic [1:0]                out_lane,
  output logic                      out_last,
  output logic                      mode_err,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned WordW  = 4 * LANE_W;
  localparam int unsigned EntryW = WordW + 2;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);
  localparam logic [1:0] ModeIllegal = 2'b10;

  typedef enum logic {StIdle, StEmit} state_e;

  // Index of the final lane emitted for a given mode.
  function automatic logic [1:0] last_lane(input logic [1:0] mode);
    unique case (mode)
      2'b00:   return 2'd3;
      2'b01:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Lane slot 0 is bits [LANE_W-1:0]; emission walks slots from high to low.
  function automatic logic [LANE_W-1:0] pick(input logic [WordW-1:0] word,
                                             input logic [1:0] slot);
    unique case (slot)
      2'd0:    return word[LANE_W-1:0];
      2'd1:    return word[2*LANE_W-1:LANE_W];
      2'd2:    return word[3*LANE_W-1:2*LANE_W];
      default: return word[4*LANE_W-1:3*LANE_W];
    endcase
  endfunction

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop, load;

  state_e            state_q, state_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [1:0]        wmode_q, wmode_d;
  logic [1:0]        lane_q, lane_d;
  logic              valid_q, valid_d;
  logic [LANE_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic [1:0]        head_mode;
  logic [WordW-1:0]  head_data;
  logic              empty, head_legal;
  logic [1:0]        slot;

  assign head_mode  = mem_q[rd_ptr_q][EntryW-1 -: 2];
  assign head_data  = mem_q[rd_ptr_q][WordW-1:0];
  assign empty      = (count_q == '0);
  assign head_legal = !empty && (head_mode != ModeIllegal);

  // No full-bypass: a same-cycle pop does not open the input.
  assign in_ready = (count_q != Full);
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wmode_d = wmode_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    slot    = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (head_mode == ModeIllegal) begin
            pop   = 1'b1;
            err_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (lane_q != last_lane(wmode_q)) begin
            lane_d = lane_q + 2'd1;
            slot   = last_lane(wmode_q) - lane_d;
            data_d = pick(word_q, slot);
            last_d = (lane_d == last_lane(wmode_q));
          end else if (head_legal) begin
            load = 1'b1;
          end else begin
            // An illegal head is left for IDLE to discard next cycle.
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      pop     = 1'b1;
      word_d  = head_data;
      wmode_d = head_mode;
      lane_d  = 2'd0;
      valid_d = 1'b1;
      slot    = last_lane(head_mode);
      data_d  = pick(head_data, slot);
      last_d  = (last_lane(head_mode) == 2'd0);
      state_d = StEmit;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {in_mode, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      word_q   <= '0;
      wmode_q  <= '0;
      lane_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      state_q <= state_d;
      word_q  <= word_d;
      wmode_q <= wmode_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_lane   = lane_q;
  assign out_last   = last_q;
  assign mode_err   = err_q;
  assign fifo_count = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= Full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_psum_unpacker.sv
// Self-checking bench for psum_unpacker: table vectors, directed corner sequences and a
// randomized phase checked against a lane-stream reference model.
module tb_psum_unpacker;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = 2'b00;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        mode_err;
  logic [2:0]  fifo_count;

  psum_unpacker #(.LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .mode_err(mode_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  lane;
    logic        last;
  } lane_t;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] data;
    int          n;
    logic [63:0] lanes;  // expected lanes, first emitted in the top 16 bits
  } vec_t;

  lane_t exp_q[$];
  int    err_exp = 0;
  int    err_seen = 0;
  logic  held = 1'b0;
  lane_t held_v;
  lane_t e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a word of mode m yields 4/2/1 lanes, most significant used lane first.
  function automatic void model_push(input logic [1:0] mode, input logic [63:0] data);
    int n;
    lane_t l;
    if (mode == 2'b10) begin
      err_exp++;
      return;
    end
    n = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      l.data = 16'((data >> (16 * (n - 1 - i))) & 64'hFFFF);
      l.lane = 2'(i);
      l.last = (i == n - 1);
      exp_q.push_back(l);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
      err_exp = err_seen;
    end else begin
      if (mode_err) err_seen++;
      if (held) chk("stall_hold", {out_valid, out_data, out_lane, out_last}, {1'b1, held_v});
      held = out_valid && !out_ready;
      held_v = '{out_data, out_lane, out_last};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL stream_extra: got lane data 0x%0h, expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("stream", {out_data, out_lane, out_last}, e);
        end
      end
      if (in_valid && in_ready) model_push(in_mode, in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid && fifo_count == 0) break;
      step();
    end
    step();
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_errs"}, 64'(err_seen), 64'(err_exp));
  endtask

  function automatic logic [63:0] qword(input int k);
    return {16'(16 * k + 1), 16'(16 * k + 2), 16'(16 * k + 3), 16'(16 * k + 4)};
  endfunction

  initial begin
    vec_t        tbl[7];
    logic [63:0] lv;
    int          e0;

    tbl[0] = '{2'b00, 64'h0004_0003_0002_0001, 4, 64'h0004_0003_0002_0001};
    tbl[1] = '{2'b01, 64'hFFFF_FFFF_00A0_00B0, 2, 64'h00A0_00B0_0000_0000};
    tbl[2] = '{2'b11, 64'h0000_0000_0000_1234, 1, 64'h1234_0000_0000_0000};
    tbl[3] = '{2'b10, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0};
    tbl[4] = '{2'b00, 64'h1234_5678_9ABC_DEF0, 4, 64'h1234_5678_9ABC_DEF0};
    tbl[5] = '{2'b11, 64'hAAAA_BBBB_CCCC_5555, 1, 64'h5555_0000_0000_0000};
    tbl[6] = '{2'b01, 64'h0101_0202_F00D_BEEF, 2, 64'hF00D_BEEF_0000_0000};

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_lane", 64'(out_lane), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_mode_err", 64'(mode_err), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Table: single word into an idle block, continuous out_ready
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      lv = tbl[k].lanes;
      in_valid = 1'b1;
      in_mode = tbl[k].mode;
      in_data = tbl[k].data;
      chk($sformatf("tbl%0d_in_ready", k), 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_latency_gap", k), 64'(out_valid), 64'd0);
      step();
      if (tbl[k].n == 0) begin
        chk($sformatf("tbl%0d_mode_err", k), 64'(mode_err), 64'd1);
        chk($sformatf("tbl%0d_no_out", k), 64'(out_valid), 64'd0);
        step();
        chk($sformatf("tbl%0d_err_pulse_end", k), 64'(mode_err), 64'd0);
      end else begin
        for (int i = 0; i < tbl[k].n; i++) begin
          chk($sformatf("tbl%0d_lane%0d", k, i), {out_valid, out_data, out_lane, out_last},
              {1'b1, lv[63-16*i -: 16], 2'(i), (i == tbl[k].n - 1)});
          step();
        end
      end
      chk($sformatf("tbl%0d_done", k), 64'(out_valid), 64'd0);
    end

    // Back-to-back mode 01 then mode 11, no bubble between words
    in_valid = 1'b1;
    in_mode = 2'b01;
    in_data = 64'hFFFF_FFFF_00A0_00B0;
    step();
    in_mode = 2'b11;
    in_data = 64'h0000_0000_0000_1234;
    step();
    in_valid = 1'b0;
    chk("b2b_0", {out_valid, out_data, out_lane, out_last}, {1'b1, 16'h00A0, 2'd0, 1'b0});
    step();
    chk("b2b_1", {out_valid, out_data, out_lane, out_last}, {1'b1, 16'h00B0, 2'd1, 1'b1});
    step();
    chk("b2b_2", {out_valid, out_data, out_lane, out_last}, {1'b1, 16'h1234, 2'd0, 1'b1});
    step();
    chk("b2b_end", 64'(out_valid), 64'd0);
    drain("b2b");

    // Backpressure: fill FIFO behind a held word
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_mode = 2'b00;
      in_data = qword(k);
      step();
    end
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", {out_valid, out_data, out_lane}, {1'b1, 16'h0001, 2'd0});
    in_data = qword(5);
    step();
    step();
    chk("full_count_held", 64'(fifo_count), 64'd4);
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("full_still_blocked", 64'(in_ready), 64'd0);
    step();
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    drain("backpressure");

    // Illegal mode between two mode-11 words
    e0 = err_seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_mode = 2'b11;
    in_data = 64'h0000_0000_0000_1111;
    step();
    in_mode = 2'b10;
    in_data = 64'h5555_6666_7777_8888;
    step();
    in_mode = 2'b11;
    in_data = 64'h0000_0000_0000_2222;
    step();
    in_valid = 1'b0;
    drain("illegal");
    chk("illegal_pulses", 64'(err_seen - e0), 64'd1);

    // Stall mid-word: ready 1,0,0,1
    in_valid = 1'b1;
    in_mode = 2'b00;
    in_data = 64'h4444_3333_2222_1111;
    step();
    in_valid = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    chk("stall_lane1", {out_valid, out_data, out_lane, out_last}, {1'b1, 16'h3333, 2'd1, 1'b0});
    step();
    chk("stall_hold1", {out_valid, out_data, out_lane, out_last}, {1'b1, 16'h3333, 2'd1, 1'b0});
    step();
    chk("stall_hold2", {out_valid, out_data, out_lane, out_last}, {1'b1, 16'h3333, 2'd1, 1'b0});
    out_ready = 1'b1;
    step();
    chk("stall_lane2", {out_valid, out_data, out_lane, out_last}, {1'b1, 16'h2222, 2'd2, 1'b0});
    drain("stall");

    // Reset during lane 1 with two words queued
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_mode = 2'b00;
      in_data = qword(k + 8);
      step();
    end
    in_valid = 1'b0;
    chk("mid_rst_queued", 64'(fifo_count), 64'd2);
    out_ready = 1'b1;
    step();
    chk("mid_rst_lane1", 64'(out_lane), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out", {out_valid, out_data, out_lane, out_last}, 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mode = 2'b00;
    in_data = 64'hCAFE_0003_0002_0001;
    step();
    in_valid = 1'b0;
    step();
    chk("after_rst_lane0", {out_valid, out_data, out_lane}, {1'b1, 16'hCAFE, 2'd0});
    drain("after_rst");

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_mode = 2'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
